pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage pipeline. It generates per-stage write enables and bubble inserts for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It selects operand forwarding for the EXE stage and sequences multi-cycle data-memory accesses with a request/acknowledge handshake and a watchdog. It keeps a saturating stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 15: max WAIT-state cycles before the controller declares a memory timeout (1..255)
- CNT_W, 16: stall counter width

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- rs, rt  in  5 each  ID-stage source register numbers
- use_rs, use_rt  in  1 each  ID instruction reads rs / rt
- ewreg, em2reg  in  1 each  EXE-stage regwrite / load flags
- edestReg  in  5  EXE-stage destination
- mwreg, mm2reg, mwmem  in  1 each  MEM-stage regwrite / load / store flags
- mdestReg  in  5  MEM-stage destination
- mem_ack  in  1  data memory completes current access
- pc_en, ifid_en, idexe_en, exemem_en, memwb_en  out  1 each  register write enables
- idexe_bubble, memwb_bubble  out  1 each  load zeroed control fields (NOP) into that register
- fwda, fwdb  out  2 each  operand select: 0 regfile, 1 EXE result r, 2 MEM mr, 3 MEM load data
- mem_req  out  1  data memory access request
- mem_timeout  out  1  sticky watchdog error
- stall_count  out  CNT_W  cycles with pc_en=0, saturating

## Operation
- States: RUN, WAIT, ERR. The controller also holds a wait counter wcnt (8 bit).
- memop = mm2reg | mwmem.
- mem_req = memop in RUN or WAIT. mem_req = 0 in ERR and during reset.
- RUN, memop & !mem_ack: next state is WAIT and wcnt<=1. Same cycle, and every WAIT cycle without ack:
  - pc_en = ifid_en = idexe_en = exemem_en = 0
  - memwb_en = 1 with memwb_bubble = 1
- WAIT & mem_ack: next state RUN, wcnt<=0. This cycle: all enables 1, no bubbles (the MEM instruction advances).
- WAIT & !mem_ack & wcnt==MEM_TIMEOUT: next state ERR. Otherwise wcnt++.
- ERR: all enables 0, memwb_bubble=1, mem_timeout=1. The controller leaves ERR only on reset.
- Load-use hazard (RUN, no memory stall this cycle):
  - Condition: ewreg & em2reg & edestReg!=0 & ((use_rs & rs==edestReg) | (use_rt & rt==edestReg)).
  - Response: pc_en=ifid_en=0, idexe_en=1 with idexe_bubble=1, exemem_en=memwb_en=1.
- Priority: ERR > memory stall > load-use > normal. In normal operation all enables are 1 and both bubbles are 0.
- Forwarding for fwda (rs); fwdb is identical with rt:
  - 1 if ewreg & !em2reg & edestReg!=0 & edestReg==rs.
  - Else 2 or 3 if mwreg & mdestReg!=0 & mdestReg==rs: 3 when mm2reg, 2 otherwise.
  - Else 0.
  - EXE-stage match beats MEM-stage match. Register 0 is never forwarded.
- stall_count increments on every clock edge where pc_en=0, including ERR. It holds at all-ones.

## Timing
- Enables, bubbles, forwarding selects and mem_req are combinational from inputs and state, valid in the same cycle.
- State, wcnt, mem_timeout and stall_count update on the rising clock edge.
- Reset (async, any time, including mid-WAIT): state=RUN, wcnt=0, mem_timeout=0, stall_count=0.
  - While reset is high: all enables 0, both bubbles 1, mem_req 0, fwda=fwdb=0.
- Single-cycle memory (mem_ack with mem_req in RUN): zero stall cycles.
- An N-cycle access (ack in the N-th request cycle) stalls the front of the pipe N-1 cycles.
- Timeout: ERR is entered at the edge after MEM_TIMEOUT+1 consecutive unacknowledged request cycles. mem_ack in the final cycle wins over timeout.
- mem_ack is ignored when mem_req=0.

## Test plan
- Back-to-back ALU ops: EXE writes $5 (ewreg=1, em2reg=0), ID reads rs=5 -> fwda=1, no stall. Same case with rs=0 and edestReg=0 -> fwda=0.
- Load-use: em2reg=1, edestReg=8, rt=8, use_rt=1, mem_ack tied 1 -> one cycle with pc_en=0, idexe_bubble=1, then normal; stall_count=1.
- MEM load to $9, rs=9, no EXE match -> fwda=3. The same with mm2reg=0 -> fwda=2. EXE and MEM both match -> fwda=1.
- 3-cycle load (mem_ack on 3rd req cycle) -> pc_en low for 2 cycles with memwb_bubble=1, enables released in ack cycle, stall_count=2.
- MEM_TIMEOUT=15, mem_ack never -> mem_timeout rises after 16 request cycles and stays. Asserting reset mid-ERR clears mem_timeout and stall_count to 0 and returns the controller to RUN.
- Load-use hazard coinciding with memory stall -> memory stall response only (idexe_bubble=0). After ack, the load-use bubble is inserted next cycle if the hazard persists.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: per-stage enables and bubbles, EXE operand forwarding,
// multi-cycle data-memory handshake with watchdog, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       edestReg,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic [4:0]       mdestReg,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idexe_en,
  output logic             exemem_en,
  output logic             memwb_en,
  output logic             idexe_bubble,
  output logic             memwb_bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q;

  logic memop, ack, mem_stall, load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (ewreg && !em2reg && (edestReg != 5'd0) && (edestReg == r)) begin
      return 2'd1;
    end else if (mwreg && (mdestReg != 5'd0) && (mdestReg == r)) begin
      return mm2reg ? 2'd3 : 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  assign memop   = mm2reg | mwmem;
  assign mem_req = memop && (state_q != StErr) && !reset;
  // An acknowledge only counts while a request is actually outstanding.
  assign ack     = mem_ack & mem_req;

  assign mem_stall = ((state_q == StRun) && memop && !ack) || ((state_q == StWait) && !ack);
  assign load_use  = ewreg && em2reg && (edestReg != 5'd0) &&
                     ((use_rs && (rs == edestReg)) || (use_rt && (rt == edestReg)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StRun: begin
        if (memop && !ack) begin
          state_d = StWait;
          wcnt_d  = 8'd1;
        end
      end
      StWait: begin
        if (ack) begin
          state_d = StRun;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TimeoutVal) begin
          state_d = StErr;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StRun;
        wcnt_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idexe_en     = 1'b1;
    exemem_en    = 1'b1;
    memwb_en     = 1'b1;
    idexe_bubble = 1'b0;
    memwb_bubble = 1'b0;
    fwda         = fwd_sel(rs);
    fwdb         = fwd_sel(rt);
    if (reset) begin
      {pc_en, ifid_en, idexe_en, exemem_en, memwb_en} = 5'b0;
      idexe_bubble = 1'b1;
      memwb_bubble = 1'b1;
      fwda         = 2'd0;
      fwdb         = 2'd0;
    end else if (state_q == StErr) begin
      {pc_en, ifid_en, idexe_en, exemem_en, memwb_en} = 5'b0;
      memwb_bubble = 1'b1;
    end else if (mem_stall) begin
      // Freeze the front of the pipe; drain a NOP into MEM/WB while memory is busy.
      {pc_en, ifid_en, idexe_en, exemem_en} = 4'b0;
      memwb_bubble = 1'b1;
    end else if ((state_q == StRun) && load_use) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idexe_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!pc_en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign mem_timeout = (state_q == StErr);
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, a request-cycle-counting reference model
// compared every cycle, and literal spot checks.
module tb_pipe_hazard_ctrl;
  localparam int MT = 15;
  localparam int CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rs = '0, rt = '0, edestReg = '0, mdestReg = '0;
  logic          use_rs = 0, use_rt = 0, ewreg = 0, em2reg = 0;
  logic          mwreg = 0, mm2reg = 0, mwmem = 0, mem_ack = 0;
  logic          pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
  logic          idexe_bubble, memwb_bubble, mem_req, mem_timeout;
  logic [1:0]    fwda, fwdb;
  logic [CW-1:0] stall_count;

  int tests = 0;
  int fails = 0;

  // Reference model state: consecutive unacknowledged request cycles, error flag, stall count.
  int reqcyc = 0;
  bit err = 0;
  int stalls = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .ewreg(ewreg), .em2reg(em2reg), .edestReg(edestReg), .mwreg(mwreg), .mm2reg(mm2reg),
    .mwmem(mwmem), .mdestReg(mdestReg), .mem_ack(mem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
    .idexe_en(idexe_en), .exemem_en(exemem_en), .memwb_en(memwb_en),
    .idexe_bubble(idexe_bubble), .memwb_bubble(memwb_bubble), .fwda(fwda), .fwdb(fwdb),
    .mem_req(mem_req), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (ewreg && !em2reg && edestReg == r) return 2'd1;
    if (mwreg && mdestReg == r) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  // en = {pc, ifid, idexe, exemem, memwb}; bub = {idexe, memwb}
  task automatic model_outs(output logic [4:0] en, output logic [1:0] bub,
                            output logic [1:0] fa, output logic [1:0] fb, output logic req);
    logic memop, lu;
    memop = mm2reg | mwmem;
    lu = ewreg && em2reg && edestReg != 0 &&
         ((use_rs && rs == edestReg) || (use_rt && rt == edestReg));
    fa = mfwd(rs);
    fb = mfwd(rt);
    if (reset) begin
      en = 5'b00000; bub = 2'b11; fa = 0; fb = 0; req = 0;
    end else if (err) begin
      en = 5'b00000; bub = 2'b01; req = 0;
    end else begin
      req = memop;
      if (memop && !mem_ack) begin
        en = 5'b00001; bub = 2'b01;
      end else if (reqcyc == 0 && lu) begin
        en = 5'b00111; bub = 2'b10;
      end else begin
        en = 5'b11111; bub = 2'b00;
      end
    end
  endtask

  always @(negedge clock) begin
    logic [4:0] en;
    logic [1:0] bub, fa, fb;
    logic       req;
    if (reset) begin
      reqcyc = 0; err = 0; stalls = 0;
    end
    model_outs(en, bub, fa, fb, req);
    chk("m_enables", {pc_en, ifid_en, idexe_en, exemem_en, memwb_en}, en);
    chk("m_bubbles", {idexe_bubble, memwb_bubble}, bub);
    chk("m_fwda", fwda, fa);
    chk("m_fwdb", fwdb, fb);
    chk("m_mem_req", mem_req, req);
    chk("m_mem_timeout", mem_timeout, err);
    chk("m_stall_count", stall_count, stalls);
  end

  always @(posedge clock) begin
    logic [4:0] en;
    logic [1:0] bub, fa, fb;
    logic       req;
    if (!reset) begin
      model_outs(en, bub, fa, fb, req);
      if (!en[4] && stalls < CntMax) stalls++;
      if (!err && (mm2reg || mwmem)) begin
        if (mem_ack) reqcyc = 0;
        else begin
          reqcyc++;
          if (reqcyc == MT + 1) err = 1;
        end
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    mm2reg = 1;
    @(negedge clock);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_idexe_bubble", idexe_bubble, 1);
    chk("rst_mem_req", mem_req, 0);
    next(); reset = 0; mm2reg = 0;
    @(negedge clock); chk("idle_stall_count", stall_count, 0);

    next(); ewreg = 1; edestReg = 5; rs = 5; use_rs = 1;
    @(negedge clock); chk("alu_fwda", fwda, 1); chk("alu_pc_en", pc_en, 1);
    next(); rs = 0; edestReg = 0;
    @(negedge clock); chk("r0_fwda", fwda, 0);

    next(); em2reg = 1; edestReg = 8; rt = 8; use_rt = 1; mem_ack = 1; use_rs = 0;
    @(negedge clock);
    chk("lu_pc_en", pc_en, 0); chk("lu_idexe_bubble", idexe_bubble, 1); chk("lu_idexe_en", idexe_en, 1);
    next(); ewreg = 0; em2reg = 0; edestReg = 0;
    @(negedge clock); chk("lu_after_pc_en", pc_en, 1); chk("lu_stall_count", stall_count, 1);

    next(); mwreg = 1; mm2reg = 1; mdestReg = 9; rs = 9; use_rs = 1;
    @(negedge clock); chk("mem_load_fwda", fwda, 3); chk("single_cycle_pc_en", pc_en, 1);
    next(); mm2reg = 0;
    @(negedge clock); chk("mem_alu_fwda", fwda, 2); chk("no_memop_req", mem_req, 0);
    next(); ewreg = 1; edestReg = 9;
    @(negedge clock); chk("exe_beats_mem_fwda", fwda, 1);

    next(); ewreg = 0; edestReg = 0; mm2reg = 1; mdestReg = 3; mem_ack = 0;
    rs = 0; rt = 0; use_rs = 0; use_rt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("ld3_pc_en", pc_en, 0); chk("ld3_memwb_bubble", memwb_bubble, 1); chk("ld3_req", mem_req, 1);
      next();
    end
    mem_ack = 1;
    @(negedge clock); chk("ld3_ack_pc_en", pc_en, 1); chk("ld3_ack_memwb_bubble", memwb_bubble, 0);
    next(); mwreg = 0; mm2reg = 0;
    @(negedge clock); chk("ld3_stall_count", stall_count, 3);

    next(); mwreg = 1; mm2reg = 1; mdestReg = 4; mem_ack = 0;
    ewreg = 1; em2reg = 1; edestReg = 8; rt = 8; use_rt = 1;
    @(negedge clock);
    chk("mix_idexe_bubble", idexe_bubble, 0); chk("mix_idexe_en", idexe_en, 0);
    chk("mix_memwb_bubble", memwb_bubble, 1);
    next(); mem_ack = 1;
    @(negedge clock); chk("mix_ack_pc_en", pc_en, 1); chk("mix_ack_idexe_bubble", idexe_bubble, 0);
    next(); mwreg = 0; mm2reg = 0; mem_ack = 0;
    @(negedge clock); chk("mix_lu_idexe_bubble", idexe_bubble, 1); chk("mix_lu_pc_en", pc_en, 0);
    next(); ewreg = 0; em2reg = 0; edestReg = 0; rt = 0; use_rt = 0;
    @(negedge clock); chk("mix_stall_count", stall_count, 5);

    // Acknowledge in the last allowed request cycle must not time out.
    next(); mwreg = 1; mm2reg = 1; mdestReg = 2; mem_ack = 0;
    repeat (MT) next();
    mem_ack = 1;
    @(negedge clock); chk("late_ack_pc_en", pc_en, 1); chk("late_ack_timeout", mem_timeout, 0);
    next(); mwreg = 0; mm2reg = 0; mem_ack = 0;
    @(negedge clock); chk("late_ack_timeout2", mem_timeout, 0); chk("sat_stall_count", stall_count, CntMax);

    next(); mwmem = 1;
    for (int i = 0; i <= MT; i++) begin
      @(negedge clock); chk("to_pending", mem_timeout, 0); chk("to_req", mem_req, 1);
      next();
    end
    @(negedge clock);
    chk("to_timeout", mem_timeout, 1); chk("to_req_err", mem_req, 0); chk("to_pc_en", pc_en, 0);
    next(); mem_ack = 1;
    @(negedge clock); chk("to_sticky", mem_timeout, 1);
    next(); reset = 1;
    @(negedge clock); chk("rst_err_count", stall_count, 0); chk("rst_err_timeout", mem_timeout, 0);
    next(); reset = 0;
    @(negedge clock); chk("post_rst_req", mem_req, 1); chk("post_rst_pc_en", pc_en, 1);
    next(); mwmem = 0; mem_ack = 0;
    @(negedge clock); chk("post_rst_count", stall_count, 0);

    next();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
